// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: top-level sequencer for the alarm clock.
// Converts debounced button levels into single-cycle presses. Steps the user
// through setting the time and the alarm, and holds the alarm registers.
// Detects an alarm match and runs the ring/snooze cycle that drives the buzzer.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   tick_1hz_i         one-cycle pulse per second
//   btn_{mode,inc,stop}_i  debounced button levels
//   time_{hh,mm,ss}_i  current time of day
//   mode_o             0 RUN,1 SET_T_HH,2 SET_T_MM,3 SET_A_HH,4 SET_A_MM,5 RINGING,6 SNOOZE
//   edit_{hh,mm}_o     value under edit
//   time_load_o        one-cycle load strobe with load_{hh,mm}_o
//   alarm_{hh,mm}_o    stored alarm, alarm_en_o armed flag
//   buzzer_o           high while ringing
module alarm_mode_ctrl #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MAX_S = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_1hz_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_stop_i,
    input  logic [4:0] time_hh_i,
    input  logic [5:0] time_mm_i,
    input  logic [5:0] time_ss_i,
    output logic [2:0] mode_o,
    output logic [4:0] edit_hh_o,
    output logic [5:0] edit_mm_o,
    output logic       time_load_o,
    output logic [4:0] load_hh_o,
    output logic [5:0] load_mm_o,
    output logic [4:0] alarm_hh_o,
    output logic [5:0] alarm_mm_o,
    output logic       alarm_en_o,
    output logic       buzzer_o
);

    localparam int unsigned RING_W = 7;
    localparam int unsigned SNZ_W  = 12;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MAX_S - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_T_HH = 3'd1,
        SET_T_MM = 3'd2,
        SET_A_HH = 3'd3,
        SET_A_MM = 3'd4,
        RINGING  = 3'd5,
        SNOOZE   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        edit_hh_q, edit_hh_d, load_hh_q, load_hh_d, alarm_hh_q, alarm_hh_d;
    logic [5:0]        edit_mm_q, edit_mm_d, load_mm_q, load_mm_d, alarm_mm_q, alarm_mm_d;
    logic              time_load_q, time_load_d, alarm_en_q, alarm_en_d, buzzer_q, buzzer_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic              btn_mode_q, btn_inc_q, btn_stop_q;
    logic              stop_p, mode_p, inc_p, match;

    function automatic logic [4:0] inc_hh(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_mm(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Rising-edge presses with stop > mode > inc; lower-priority presses are dropped
    assign stop_p = btn_stop_i & ~btn_stop_q;
    assign mode_p = btn_mode_i & ~btn_mode_q & ~stop_p;
    assign inc_p  = btn_inc_i & ~btn_inc_q & ~stop_p & ~(btn_mode_i & ~btn_mode_q);

    assign match = alarm_en_q & tick_1hz_i & (time_hh_i == alarm_hh_q)
                 & (time_mm_i == alarm_mm_q) & (time_ss_i == 6'd0);

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        edit_hh_d   = edit_hh_q;
        edit_mm_d   = edit_mm_q;
        time_load_d = 1'b0;
        load_hh_d   = load_hh_q;
        load_mm_d   = load_mm_q;
        alarm_hh_d  = alarm_hh_q;
        alarm_mm_d  = alarm_mm_q;
        alarm_en_d  = alarm_en_q;
        ring_d      = ring_q;
        snz_d       = snz_q;
        unique case (state_q)
            RUN: begin
                if (stop_p) begin
                    alarm_en_d = ~alarm_en_q;
                end else if (mode_p) begin
                    state_d   = SET_T_HH;
                    edit_hh_d = time_hh_i;
                    edit_mm_d = time_mm_i;
                end else if (match) begin
                    state_d = RINGING;
                    ring_d  = '0;
                end
            end
            SET_T_HH, SET_A_HH: begin
                if (stop_p) begin
                    state_d = RUN;
                end else if (mode_p) begin
                    state_d = (state_q == SET_T_HH) ? SET_T_MM : SET_A_MM;
                end else if (inc_p) begin
                    edit_hh_d = inc_hh(edit_hh_q);
                end
            end
            SET_T_MM: begin
                if (stop_p) begin
                    state_d = RUN;
                end else if (mode_p) begin
                    // Commit the time, then preload the editor with the current alarm
                    state_d     = SET_A_HH;
                    time_load_d = 1'b1;
                    load_hh_d   = edit_hh_q;
                    load_mm_d   = edit_mm_q;
                    edit_hh_d   = alarm_hh_q;
                    edit_mm_d   = alarm_mm_q;
                end else if (inc_p) begin
                    edit_mm_d = inc_mm(edit_mm_q);
                end
            end
            SET_A_MM: begin
                if (stop_p) begin
                    state_d = RUN;
                end else if (mode_p) begin
                    state_d    = RUN;
                    alarm_hh_d = edit_hh_q;
                    alarm_mm_d = edit_mm_q;
                    alarm_en_d = 1'b1;
                end else if (inc_p) begin
                    edit_mm_d = inc_mm(edit_mm_q);
                end
            end
            RINGING: begin
                if (stop_p) begin
                    state_d = RUN;
                end else if (inc_p) begin
                    state_d = SNOOZE;
                    snz_d   = SNZ_LOAD;
                end else if (tick_1hz_i) begin
                    if (ring_q >= RING_LAST) begin
                        state_d = RUN;
                    end else begin
                        ring_d = ring_q + RING_W'(1);
                    end
                end
            end
            SNOOZE: begin
                if (stop_p) begin
                    state_d = RUN;
                end else if (tick_1hz_i) begin
                    if (snz_q <= SNZ_W'(1)) begin
                        state_d = RINGING;
                        ring_d  = '0;
                        snz_d   = '0;
                    end else begin
                        snz_d = snz_q - SNZ_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
        buzzer_d = (state_d == RINGING);
    end

    // State and output registers; button history tracks levels even in reset
    always_ff @(posedge clk_i) begin
        btn_mode_q <= btn_mode_i;
        btn_inc_q  <= btn_inc_i;
        btn_stop_q <= btn_stop_i;
        if (rst_i) begin
            state_q     <= RUN;
            edit_hh_q   <= '0;
            edit_mm_q   <= '0;
            time_load_q <= 1'b0;
            load_hh_q   <= '0;
            load_mm_q   <= '0;
            alarm_hh_q  <= '0;
            alarm_mm_q  <= '0;
            alarm_en_q  <= 1'b0;
            buzzer_q    <= 1'b0;
            ring_q      <= '0;
            snz_q       <= '0;
        end else begin
            state_q     <= state_d;
            edit_hh_q   <= edit_hh_d;
            edit_mm_q   <= edit_mm_d;
            time_load_q <= time_load_d;
            load_hh_q   <= load_hh_d;
            load_mm_q   <= load_mm_d;
            alarm_hh_q  <= alarm_hh_d;
            alarm_mm_q  <= alarm_mm_d;
            alarm_en_q  <= alarm_en_d;
            buzzer_q    <= buzzer_d;
            ring_q      <= ring_d;
            snz_q       <= snz_d;
        end
    end

    assign mode_o      = state_q;
    assign edit_hh_o   = edit_hh_q;
    assign edit_mm_o   = edit_mm_q;
    assign time_load_o = time_load_q;
    assign load_hh_o   = load_hh_q;
    assign load_mm_o   = load_mm_q;
    assign alarm_hh_o  = alarm_hh_q;
    assign alarm_mm_o  = alarm_mm_q;
    assign alarm_en_o  = alarm_en_q;
    assign buzzer_o    = buzzer_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// tb_alarm_mode_ctrl: directed bench for alarm_mode_ctrl with an expectation queue.
module tb_alarm_mode_ctrl;

    localparam int S_MODE = 0, S_EHH = 1, S_EMM = 2, S_TLD = 3, S_LHH = 4,
                   S_LMM = 5, S_AHH = 6, S_AMM = 7, S_AEN = 8, S_BUZ = 9;
    localparam int B_MODE = 0, B_INC = 1, B_STOP = 2;

    typedef struct {
        int          sig;
        int unsigned val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, tick, btn_mode, btn_inc, btn_stop;
    logic [4:0] thh;
    logic [5:0] tmm, tss;
    logic [2:0] mode;
    logic [4:0] edit_hh, load_hh, alarm_hh;
    logic [5:0] edit_mm, load_mm, alarm_mm;
    logic       time_load, alarm_en, buzzer;

    exp_t  sb_q[$];
    string names [10];
    int    n_asserts = 0;
    int    n_fail    = 0;

    alarm_mode_ctrl #(.SNOOZE_MIN(1), .RING_MAX_S(60)) dut (
        .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick),
        .btn_mode_i(btn_mode), .btn_inc_i(btn_inc), .btn_stop_i(btn_stop),
        .time_hh_i(thh), .time_mm_i(tmm), .time_ss_i(tss),
        .mode_o(mode), .edit_hh_o(edit_hh), .edit_mm_o(edit_mm),
        .time_load_o(time_load), .load_hh_o(load_hh), .load_mm_o(load_mm),
        .alarm_hh_o(alarm_hh), .alarm_mm_o(alarm_mm), .alarm_en_o(alarm_en),
        .buzzer_o(buzzer)
    );

    always #5 clk = ~clk;

    function automatic int unsigned obs(input int id);
        case (id)
            S_MODE:  return 32'(mode);
            S_EHH:   return 32'(edit_hh);
            S_EMM:   return 32'(edit_mm);
            S_TLD:   return 32'(time_load);
            S_LHH:   return 32'(load_hh);
            S_LMM:   return 32'(load_mm);
            S_AHH:   return 32'(alarm_hh);
            S_AMM:   return 32'(alarm_mm);
            S_AEN:   return 32'(alarm_en);
            default: return 32'(buzzer);
        endcase
    endfunction

    task automatic push(input int sig, input int unsigned val);
        exp_t e;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then drain every queued expectation against the outputs
    task automatic step();
        exp_t e;
        int unsigned o;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs(e.sig);
            n_asserts++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", names[e.sig], o, e.val);
            end
        end
    endtask

    task automatic press(input int b);
        case (b)
            B_MODE:  btn_mode = 1'b1;
            B_INC:   btn_inc  = 1'b1;
            default: btn_stop = 1'b1;
        endcase
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_stop = 1'b0;
        step();
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) press(B_INC);
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    initial begin
        names = '{"mode", "edit_hh", "edit_mm", "time_load", "load_hh",
                  "load_mm", "alarm_hh", "alarm_mm", "alarm_en", "buzzer"};
        rst = 1'b1; tick = 1'b0; btn_mode = 1'b1; btn_inc = 1'b0; btn_stop = 1'b0;
        thh = 5'd10; tmm = 6'd15; tss = 6'd1;
        step();
        step();

        // Reset values, mode held through reset gives no press
        rst = 1'b0;
        push(S_MODE, 0); push(S_EHH, 0); push(S_TLD, 0); push(S_AHH, 0);
        push(S_AEN, 0); push(S_BUZ, 0);
        step();
        push(S_MODE, 0);
        step();
        btn_mode = 1'b0;
        step();
        push(S_MODE, 1); push(S_EHH, 10); push(S_EMM, 15);
        press(B_MODE);

        // Set time 13:05
        inc_n(3);
        push(S_EHH, 13); push(S_MODE, 1);
        step();
        push(S_MODE, 2);
        press(B_MODE);
        inc_n(50);
        push(S_EMM, 5);
        step();
        push(S_TLD, 1); push(S_LHH, 13); push(S_LMM, 5); push(S_MODE, 3);
        push(S_EHH, 0); push(S_EMM, 0);
        btn_mode = 1'b1;
        step();
        push(S_TLD, 0);
        btn_mode = 1'b0;
        step();

        // Hour and minute wrap, then set alarm 07:30
        inc_n(23);
        push(S_EHH, 23);
        step();
        push(S_EHH, 0);
        press(B_INC);
        inc_n(7);
        push(S_MODE, 4); push(S_EHH, 7); push(S_EMM, 0);
        btn_mode = 1'b1; btn_inc = 1'b1;
        step();
        btn_mode = 1'b0; btn_inc = 1'b0;
        step();
        inc_n(59);
        push(S_EMM, 59);
        step();
        push(S_EMM, 0);
        press(B_INC);
        inc_n(30);
        push(S_MODE, 0); push(S_AHH, 7); push(S_AMM, 30); push(S_AEN, 1);
        press(B_MODE);

        // Match and auto-silence after 60 s
        thh = 5'd7; tmm = 6'd30; tss = 6'd0;
        push(S_MODE, 5); push(S_BUZ, 1);
        tick_once();
        tss = 6'd1;
        for (int k = 0; k < 59; k++) tick_once();
        push(S_MODE, 5);
        step();
        push(S_MODE, 0); push(S_BUZ, 0);
        tick_once();

        // Snooze for one minute, ring again, stop
        tss = 6'd0;
        push(S_MODE, 5);
        tick_once();
        tss = 6'd1;
        push(S_MODE, 6); push(S_BUZ, 0);
        press(B_INC);
        for (int k = 0; k < 59; k++) tick_once();
        push(S_MODE, 6);
        step();
        push(S_MODE, 5); push(S_BUZ, 1);
        tick_once();
        push(S_MODE, 0); push(S_AEN, 1); push(S_BUZ, 0);
        press(B_STOP);

        // Disarm, missed match, rearm, then abort an alarm edit
        push(S_AEN, 0);
        press(B_STOP);
        tss = 6'd0;
        push(S_MODE, 0); push(S_BUZ, 0);
        tick_once();
        tss = 6'd1;
        push(S_AEN, 1);
        press(B_STOP);
        press(B_MODE);
        press(B_MODE);
        push(S_MODE, 3); push(S_EHH, 7); push(S_EMM, 30);
        press(B_MODE);
        press(B_INC);
        press(B_MODE);
        press(B_INC);
        push(S_MODE, 4); push(S_EHH, 8); push(S_EMM, 31);
        step();
        push(S_MODE, 0); push(S_AHH, 7); push(S_AMM, 30); push(S_AEN, 1); push(S_TLD, 0);
        press(B_STOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
